// File: rtl/dimc_pkg.sv
// Shared constants, state encoding and lane-count helper for the DIMC result path.
package dimc_pkg;

  localparam int DIMC_PSUM_W = 24;
  localparam int DIMC_RES_W  = 4;
  localparam int DIMC_ROWS   = 32;
  localparam int PSUM_LANE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } collector_state_t;

  function automatic int lanes_for_mode(input logic mode_psum, input int out_w);
    return mode_psum ? out_w / PSUM_LANE_W : out_w / DIMC_RES_W;
  endfunction

endpackage

// File: rtl/dimc_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a write is accepted when full only if a read frees a slot on the same edge.
module dimc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_rd;
  logic             w_wr;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_rd      = i_rd_en & ~o_empty;
  assign w_wr      = i_wr_en & (~o_full | w_rd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wr_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dimc_result_collector.sv
// Collects one frame of DIMC row results, packs them LSB-first into words and streams them out through a FIFO.
//   state   | meaning
//   IDLE    | waiting for start with a non-zero row count
//   COLLECT | capturing one row per READYN=0 cycle until the last row
//   DRAIN   | frame captured; waiting for the output FIFO to empty
module dimc_result_collector
  import dimc_pkg::*;
#(
  parameter int OUT_W      = 128,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_ROWS   = DIMC_ROWS
) (
  input  logic                   RCK,
  input  logic                   RESET,
  input  logic                   start,
  input  logic                   mode_psum,
  input  logic [5:0]             num_rows,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  input  logic                   READYN,
  input  logic [DIMC_PSUM_W-1:0] PSOUT,
  input  logic [2:0]             RES_OUT,
  input  logic                   SOUT,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [OUT_W-1:0]       m_data,
  output logic                   m_last
);

  localparam int CW = $clog2(MAX_ROWS) + 1;
  localparam int LW = $clog2(OUT_W / DIMC_RES_W);

  collector_state_t r_state;
  collector_state_t w_next_state;
  logic             r_mode;
  logic [CW-1:0]    r_num_rows;
  logic [CW-1:0]    r_row;
  logic [LW-1:0]    r_lane;
  logic [OUT_W-1:0] r_pack;
  logic             r_overflow;

  logic             w_start_ok;
  logic             w_cap;
  logic             w_last_row;
  logic             w_last_lane;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [5:0]       w_nrows_sat;
  logic [OUT_W-1:0] w_pack_next;
  int               w_lanes;

  assign w_start_ok  = (r_state == IDLE) && start && (num_rows != '0);
  assign w_nrows_sat = (num_rows > 6'(MAX_ROWS)) ? 6'(MAX_ROWS) : num_rows;
  assign w_cap       = (r_state == COLLECT) && !READYN;
  assign w_lanes     = lanes_for_mode(r_mode, OUT_W);
  assign w_last_row  = (r_row == r_num_rows - CW'(1));
  assign w_last_lane = (r_lane == LW'(w_lanes - 1));
  assign w_push      = w_cap && (w_last_lane || w_last_row);
  assign w_pop       = m_valid && m_ready;

  always_comb begin
    w_pack_next = r_pack;
    if (r_mode)
      w_pack_next[PSUM_LANE_W*r_lane +: PSUM_LANE_W] =
        {{(PSUM_LANE_W-DIMC_PSUM_W){PSOUT[DIMC_PSUM_W-1]}}, PSOUT};
    else
      w_pack_next[DIMC_RES_W*r_lane +: DIMC_RES_W] = {RES_OUT, SOUT};
  end

  always_ff @(posedge RCK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_next_state = COLLECT;
      COLLECT: if (w_cap && w_last_row) w_next_state = DRAIN;
      DRAIN:   if (w_empty) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DRAIN) && w_empty;
  end

  always_ff @(posedge RCK) begin
    if (RESET) begin
      r_mode     <= 1'b0;
      r_num_rows <= '0;
      r_row      <= '0;
      r_lane     <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_ok) begin
      r_mode     <= mode_psum;
      r_num_rows <= CW'(w_nrows_sat);
      r_row      <= '0;
      r_lane     <= '0;
      r_pack     <= '0;
      r_overflow <= 1'b0;
    end else if (w_cap) begin
      r_row <= r_row + CW'(1);
      if (w_push) begin
        r_lane <= '0;
        r_pack <= '0;
      end else begin
        r_lane <= r_lane + LW'(1);
        r_pack <= w_pack_next;
      end
      // DIMC cannot stall, so a word with nowhere to go is lost
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign overflow = r_overflow;
  assign m_valid  = !w_empty;

  dimc_sync_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (RCK),
    .i_rst     (RESET),
    .i_wr_en   (w_push),
    .i_wr_data ({w_last_row, w_pack_next}),
    .i_rd_en   (m_ready),
    .o_rd_data ({m_last, m_data}),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

endmodule
